// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the sharing-controller FSM encoding.
package alu_pkg;

    localparam logic [2:0] OP_NOP0 = 3'b000;
    localparam logic [2:0] OP_NOP1 = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ADDI = 3'b110;
    localparam logic [2:0] OP_SUBI = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; on a tie the requester that did not win last time gets the grant.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters:
// accept in IDLE, drive the ALU for one EXEC cycle, hold the result in RESP until taken.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [W-1:0]     rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [W-1:0]     rsp1_data,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic [2:0]       alu_op,
    input  logic [W-1:0]     alu_result,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t         state, state_nxt;
    logic [1:0]     grant;
    logic [W-1:0]   opnd_a, opnd_b, result_reg;
    logic [2:0]     opnd_op;
    logic           owner, last_grant;
    logic           accept, rsp_hs;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign accept = (state == IDLE) && (grant != 2'b00);
    assign rsp_hs = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

    // Data lines stay on the result register; only the valids say who owns it.
    assign rsp0_data = result_reg;
    assign rsp1_data = result_reg;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = OP_NOP0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (grant != 2'b00)
                    state_nxt = EXEC;
            end
            EXEC: begin
                alu_a     = opnd_a;
                alu_b     = opnd_b;
                alu_op    = opnd_op;
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                if (rsp_hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= OP_NOP0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            result_reg <= '0;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                opnd_a  <= grant[1] ? req1_a  : req0_a;
                opnd_b  <= grant[1] ? req1_b  : req0_b;
                opnd_op <= grant[1] ? req1_op : req0_op;
                owner   <= grant[1];
            end
            if (state == EXEC)
                result_reg <= alu_result;
            if (rsp_hs) begin
                last_grant <= owner;
                ops_done   <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, scoreboard on response handshakes,
// a table of single operations and hand-written arbitration/stall/reset sequences.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int W = 32;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
    logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0] req0_op = 0, req1_op = 0, alu_op;
    logic [W-1:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
    logic [CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_ADD, OP_ADDI: return a + b;
            OP_SUB, OP_SUBI: return a - b;
            OP_SHL:          return a << b;
            OP_SHR:          return a >> b;
            default:         return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_op, alu_a, alu_b);

    alu_share_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .busy(busy), .ops_done(ops_done)
    );

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; } opr_t;
    typedef struct { logic owner; logic [31:0] data; } sbe_t;

    int checks = 0, failures = 0;
    sbe_t sb[$];
    opr_t q0[$], q1[$];
    int grant_log[$];
    logic [31:0] rsp_log[$];
    logic hs0, hs1, rh0, rh1;
    int last_rsp_cyc;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic rsp_check(int n, logic [31:0] data);
        sbe_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_underflow actual=rsp%0d expected=none", n);
        end else begin
            e = sb.pop_front();
            chk("rsp_owner", 32'(n), 32'(e.owner));
            chk("rsp_data", data, e.data);
            rsp_log.push_back(data);
        end
    endtask

    // Evaluate the current cycle (inputs already driven) before the next rising edge.
    task automatic sample();
        #1;
        hs0 = req0_valid & req0_ready;
        hs1 = req1_valid & req1_ready;
        rh0 = rsp0_valid & rsp0_ready;
        rh1 = rsp1_valid & rsp1_ready;
        chk("ready_while_busy", 32'(busy & (req0_ready | req1_ready)), 32'd0);
        chk("dual_rsp_valid", 32'(rsp0_valid & rsp1_valid), 32'd0);
        if (hs0) begin
            sb.push_back('{1'b0, alu_ref(req0_op, req0_a, req0_b)});
            grant_log.push_back(0);
        end
        if (hs1) begin
            sb.push_back('{1'b1, alu_ref(req1_op, req1_a, req1_b)});
            grant_log.push_back(1);
        end
        if (rh0) rsp_check(0, rsp0_data);
        if (rh1) rsp_check(1, rsp1_data);
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic load();
        req0_valid = (q0.size() != 0);
        req1_valid = (q1.size() != 0);
        if (q0.size() != 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
        if (q1.size() != 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
    endtask

    // Drain q0/q1 through the DUT with both response readies high.
    task automatic run(int maxc);
        grant_log.delete();
        rsp_log.delete();
        last_rsp_cyc = -1;
        rsp0_ready = 1;
        rsp1_ready = 1;
        load();
        for (int c = 0; c < maxc; c++) begin
            sample();
            if (rh0 || rh1) last_rsp_cyc = c;
            if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !busy) begin
                adv();
                return;
            end
            adv();
            if (hs0) void'(q0.pop_front());
            if (hs1) void'(q1.pop_front());
            load();
        end
        checks++;
        failures++;
        $display("FAIL run_timeout actual=%0d expected=<%0d cycles", maxc, maxc);
        q0.delete();
        q1.delete();
        load();
    endtask

    task automatic do_reset();
        rst = 1;
        adv();
        adv();
        sb.delete();
        rst = 0;
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{OP_NOP1, 32'd9,          32'd9,  32'd0};
        tbl[1] = '{OP_SHR,  32'h8000_0000,  32'd31, 32'd1};
        tbl[2] = '{OP_ADDI, 32'hFFFF_FFFF,  32'd1,  32'd0};
        tbl[3] = '{OP_ADD,  32'd5,          32'd7,  32'd12};
        tbl[4] = '{OP_SUB,  32'd3,          32'd10, 32'hFFFF_FFF9};
        tbl[5] = '{OP_SHL,  32'd1,          32'd4,  32'd16};
        tbl[6] = '{OP_SUBI, 32'd0,          32'd1,  32'hFFFF_FFFF};
        tbl[7] = '{OP_NOP0, 32'h1234,       32'h55, 32'd0};

        // Reset state
        adv();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ops_done", 32'(ops_done), 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp0_data, 0);
        chk("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
        chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
        adv();
        rst = 0;

        // Single ADD on requester 0, cycle by cycle
        req0_valid = 1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
        rsp0_ready = 1; rsp1_ready = 1;
        sample();
        chk("t1_req0_ready_c0", 32'(req0_ready), 1);
        adv();
        req0_valid = 0;
        sample();
        chk("t1_alu_op_c1", 32'(alu_op), 32'(OP_ADD));
        chk("t1_alu_a_c1", alu_a, 5);
        chk("t1_alu_b_c1", alu_b, 7);
        chk("t1_busy_c1", 32'(busy), 1);
        adv();
        sample();
        chk("t1_rsp0_valid_c2", 32'(rsp0_valid), 1);
        chk("t1_rsp0_data_c2", rsp0_data, 12);
        chk("t1_rsp1_valid_c2", 32'(rsp1_valid), 0);
        adv();
        sample();
        chk("t1_ops_done", 32'(ops_done), 1);
        chk("t1_busy_c3", 32'(busy), 0);
        chk("t1_alu_op_idle", 32'(alu_op), 0);
        adv();

        // Tie straight after reset: requester 0 first
        do_reset();
        q0.push_back('{OP_SUB, 32'd10, 32'd3});
        q1.push_back('{OP_SHL, 32'd1, 32'd4});
        run(30);
        chk("t2_grants", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            chk("t2_grant0", 32'(grant_log[0]), 0);
            chk("t2_grant1", 32'(grant_log[1]), 1);
            chk("t2_data0", rsp_log[0], 7);
            chk("t2_data1", rsp_log[1], 16);
        end

        // Six back-to-back contended ops alternate, 3 cycles each
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{OP_ADD, 32'(i * 100), 32'(i + 1)});
            q1.push_back('{OP_SUB, 32'(i * 7), 32'd2});
        end
        run(60);
        chk("t3_grants", 32'(grant_log.size()), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("t3_grant_order", 32'(grant_log[i]), 32'(i % 2));
        chk("t3_last_rsp_cycle", 32'(last_rsp_cyc), 17);
        chk("t3_ops_done", 32'(ops_done), 8);

        // Stalled response blocks requester 1
        req0_valid = 1; req0_op = OP_ADD; req0_a = 100; req0_b = 23;
        req1_valid = 1; req1_op = OP_SUB; req1_a = 50; req1_b = 8;
        rsp0_ready = 0;
        sample();
        chk("t4_req0_ready", 32'(req0_ready), 1);
        chk("t4_req1_ready_idle", 32'(req1_ready), 0);
        adv();
        req0_valid = 0;
        sample();
        chk("t4_req1_ready_exec", 32'(req1_ready), 0);
        adv();
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t4_stall_valid", 32'(rsp0_valid), 1);
            chk("t4_stall_data", rsp0_data, 123);
            chk("t4_stall_req1_ready", 32'(req1_ready), 0);
            adv();
        end
        rsp0_ready = 1;
        sample();
        chk("t4_rsp0_hs", 32'(rh0), 1);
        chk("t4_req1_ready_resp", 32'(req1_ready), 0);
        adv();
        q1.push_back('{OP_SUB, 32'd50, 32'd8});
        run(20);
        chk("t4_grants", 32'(grant_log.size()), 1);
        if (grant_log.size() == 1) begin
            chk("t4_grant", 32'(grant_log[0]), 1);
            chk("t4_data", rsp_log[0], 42);
        end
        chk("t4_ops_done", 32'(ops_done), 10);

        // Table of single operations, alternating requesters
        foreach (tbl[i]) begin
            if (i % 2 == 0) q0.push_back('{tbl[i].op, tbl[i].a, tbl[i].b});
            else            q1.push_back('{tbl[i].op, tbl[i].a, tbl[i].b});
            run(20);
            chk("tbl_count", 32'(rsp_log.size()), 1);
            if (rsp_log.size() == 1) chk("tbl_data", rsp_log[0], tbl[i].exp);
        end
        chk("tbl_ops_done", 32'(ops_done), 18);

        // Reset asserted while EXEC: op dropped, counter cleared
        req0_valid = 1; req0_op = OP_ADD; req0_a = 1; req0_b = 2;
        sample();
        chk("t5_accept", 32'(hs0), 1);
        adv();
        req0_valid = 0;
        sample();
        chk("t5_in_exec", 32'(alu_op), 32'(OP_ADD));
        rst = 1;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ops_done", 32'(ops_done), 0);
        chk("t5_alu_op", 32'(alu_op), 0);
        chk("t5_alu_a", alu_a, 0);
        sb.delete();
        adv();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("t5_no_rsp", 32'({rsp1_valid, rsp0_valid}), 0);
            adv();
        end
        q0.push_back('{OP_ADD, 32'd2, 32'd3});
        q1.push_back('{OP_SUB, 32'd9, 32'd4});
        run(30);
        chk("t5_grants", 32'(grant_log.size()), 2);
        if (grant_log.size() == 2) begin
            chk("t5_grant0", 32'(grant_log[0]), 0);
            chk("t5_data0", rsp_log[0], 5);
            chk("t5_data1", rsp_log[1], 5);
        end
        chk("t5_ops_done_after", 32'(ops_done), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
